// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback mux for the RISC-V core.
// Handles load extraction, the register-file write port, forwarding taps, the retire counter and the sticky load-fault flag.
module writeback_stage #(
    parameter int CNT_W    = 32,
    parameter bit X0_GUARD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_result_src,
    input  logic [2:0]       mem_funct3,
    input  logic [31:0]      mem_alu_result,
    input  logic [31:0]      mem_read_data,
    input  logic [31:0]      mem_pc_plus4,
    input  logic             stall_wb,
    input  logic             flush_wb,
    input  logic             fault_clr,
    output logic [4:0]       rf_a3,
    output logic [31:0]      rf_wd3,
    output logic             rf_we3,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [31:0]      fwd_data,
    output logic [CNT_W-1:0] retire_count,
    output logic             load_fault,
    output logic [31:0]      fault_addr
);

    logic             wb_valid_q, wb_valid_d;
    logic             wb_reg_write_q, wb_reg_write_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [1:0]       wb_result_src_q, wb_result_src_d;
    logic [2:0]       wb_funct3_q, wb_funct3_d;
    logic [31:0]      wb_alu_result_q, wb_alu_result_d;
    logic [31:0]      wb_read_data_q, wb_read_data_d;
    logic [31:0]      wb_pc_plus4_q, wb_pc_plus4_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic             load_fault_q, load_fault_d;
    logic [31:0]      fault_addr_q, fault_addr_d;

    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic        fault_cond;
    logic        fault;
    logic [31:0] wd_mux;
    logic        we;

    always_comb begin
        wb_valid_d      = wb_valid_q;
        wb_reg_write_d  = wb_reg_write_q;
        wb_rd_d         = wb_rd_q;
        wb_result_src_d = wb_result_src_q;
        wb_funct3_d     = wb_funct3_q;
        wb_alu_result_d = wb_alu_result_q;
        wb_read_data_d  = wb_read_data_q;
        wb_pc_plus4_d   = wb_pc_plus4_q;
        if (flush_wb) begin
            wb_valid_d = 1'b0;
        end else if (!stall_wb) begin
            wb_valid_d      = mem_valid;
            wb_reg_write_d  = mem_reg_write;
            wb_rd_d         = mem_rd;
            wb_result_src_d = mem_result_src;
            wb_funct3_d     = mem_funct3;
            wb_alu_result_d = mem_alu_result;
            wb_read_data_d  = mem_read_data;
            wb_pc_plus4_d   = mem_pc_plus4;
        end
    end

    always_comb begin
        off     = wb_alu_result_q[1:0];
        ld_byte = 8'(wb_read_data_q >> {off, 3'b000});
        ld_half = off[1] ? wb_read_data_q[31:16] : wb_read_data_q[15:0];
        ld_val  = wb_read_data_q;
        fault_cond = 1'b1;
        case (wb_funct3_q)
            3'b000: begin ld_val = {{24{ld_byte[7]}}, ld_byte}; fault_cond = 1'b0;       end
            3'b100: begin ld_val = {24'd0, ld_byte};            fault_cond = 1'b0;       end
            3'b001: begin ld_val = {{16{ld_half[15]}}, ld_half}; fault_cond = off[0];    end
            3'b101: begin ld_val = {16'd0, ld_half};            fault_cond = off[0];     end
            3'b010: begin ld_val = wb_read_data_q;              fault_cond = (off != 2'd0); end
            default: begin ld_val = wb_read_data_q;             fault_cond = 1'b1;       end
        endcase
        fault = wb_valid_q && (wb_result_src_q == 2'b01) && fault_cond;

        case (wb_result_src_q)
            2'b01:   wd_mux = ld_val;
            2'b10:   wd_mux = wb_pc_plus4_q;
            default: wd_mux = wb_alu_result_q;
        endcase
        we = wb_valid_q && wb_reg_write_q && !fault && !(X0_GUARD && (wb_rd_q == 5'd0));
    end

    // A new fault in the same cycle as a clear re-arms the flag with the new address.
    always_comb begin
        retire_d     = retire_q;
        load_fault_d = load_fault_q;
        fault_addr_d = fault_addr_q;
        if (wb_valid_q && !stall_wb && !flush_wb)
            retire_d = retire_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (fault && !stall_wb) begin
            load_fault_d = 1'b1;
            if (!load_fault_q || fault_clr)
                fault_addr_d = wb_alu_result_q;
        end else if (fault_clr) begin
            load_fault_d = 1'b0;
            fault_addr_d = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_rd_q         <= 5'd0;
            wb_result_src_q <= 2'd0;
            wb_funct3_q     <= 3'd0;
            wb_alu_result_q <= 32'd0;
            wb_read_data_q  <= 32'd0;
            wb_pc_plus4_q   <= 32'd0;
            retire_q        <= '0;
            load_fault_q    <= 1'b0;
            fault_addr_q    <= 32'd0;
        end else begin
            wb_valid_q      <= wb_valid_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_rd_q         <= wb_rd_d;
            wb_result_src_q <= wb_result_src_d;
            wb_funct3_q     <= wb_funct3_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_read_data_q  <= wb_read_data_d;
            wb_pc_plus4_q   <= wb_pc_plus4_d;
            retire_q        <= retire_d;
            load_fault_q    <= load_fault_d;
            fault_addr_q    <= fault_addr_d;
        end
    end

    assign rf_a3        = wb_rd_q;
    assign rf_wd3       = wd_mux;
    assign rf_we3       = we;
    assign fwd_valid    = we;
    assign fwd_rd       = wb_rd_q;
    assign fwd_data     = wd_mux;
    assign retire_count = retire_q;
    assign load_fault   = load_fault_q;
    assign fault_addr   = fault_addr_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed test-plan cases plus randomized traffic
// compared against a transaction-level model of the WB slot, retire counter and fault flag.
module tb_writeback_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             mem_valid, mem_reg_write;
    logic [4:0]       mem_rd;
    logic [1:0]       mem_result_src;
    logic [2:0]       mem_funct3;
    logic [31:0]      mem_alu_result, mem_read_data, mem_pc_plus4;
    logic             stall_wb, flush_wb, fault_clr;
    logic [4:0]       rf_a3, fwd_rd;
    logic [31:0]      rf_wd3, fwd_data, fault_addr;
    logic             rf_we3, fwd_valid, load_fault;
    logic [CNT_W-1:0] retire_count;

    writeback_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_result_src(mem_result_src), .mem_funct3(mem_funct3),
        .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
        .mem_pc_plus4(mem_pc_plus4), .stall_wb(stall_wb), .flush_wb(flush_wb),
        .fault_clr(fault_clr), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retire_count(retire_count), .load_fault(load_fault), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the instruction sitting in WB, plus architectural counters.
    typedef struct {
        bit        valid, rw, known;
        bit [4:0]  rd;
        bit [1:0]  src;
        bit [2:0]  f3;
        bit [31:0] alu, rdata, pc;
    } wb_t;

    wb_t       m;
    int        m_cnt;
    bit        m_flag;
    bit [31:0] m_addr;

    function automatic bit legal_f3(input bit [2:0] f3);
        return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5;
    endfunction

    function automatic bit is_fault(input wb_t w);
        int size;
        if (!w.valid || w.src != 2'b01) return 1'b0;
        if (!legal_f3(w.f3)) return 1'b1;
        size = (w.f3 == 3'd2) ? 4 : (w.f3 == 3'd1 || w.f3 == 3'd5) ? 2 : 1;
        return (w.alu % size) != 0;
    endfunction

    function automatic bit [31:0] exp_wd(input wb_t w);
        int unsigned off, b, h;
        off = w.alu % 4;
        b = (w.rdata >> (8 * off)) % 256;
        h = (w.rdata >> (16 * (off / 2))) % 65536;
        if (w.src == 2'b10) return w.pc;
        if (w.src != 2'b01) return w.alu;
        case (w.f3)
            3'd0:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            3'd5:    return 32'(h);
            default: return w.rdata;
        endcase
    endfunction

    task automatic model_reset();
        m = '{valid: 0, rw: 0, known: 1, rd: 0, src: 0, f3: 0, alu: 0, rdata: 0, pc: 0};
        m_cnt = 0; m_flag = 0; m_addr = 0;
    endtask

    task automatic check_outputs();
        bit exp_we;
        exp_we = m.valid && m.rw && !is_fault(m) && m.rd != 5'd0;
        check("rf_we3", 32'(rf_we3), 32'(exp_we));
        check("fwd_valid", 32'(fwd_valid), 32'(exp_we));
        if (m.known) begin
            check("rf_a3", 32'(rf_a3), 32'(m.rd));
            check("fwd_rd", 32'(fwd_rd), 32'(m.rd));
            if (!(m.src == 2'b01 && !legal_f3(m.f3))) begin
                check("rf_wd3", rf_wd3, exp_wd(m));
                check("fwd_data", fwd_data, exp_wd(m));
            end
        end
        check("retire_count", 32'(retire_count), 32'(m_cnt % 16));
        check("load_fault", 32'(load_fault), 32'(m_flag));
        check("fault_addr", fault_addr, m_addr);
    endtask

    task automatic drive(input bit v, input bit rw, input bit [4:0] rd, input bit [1:0] src,
                         input bit [2:0] f3, input bit [31:0] alu, input bit [31:0] rdata,
                         input bit [31:0] pc, input bit st, input bit fl, input bit clr);
        wb_t nm;
        bit  f;
        mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_result_src = src;
        mem_funct3 = f3; mem_alu_result = alu; mem_read_data = rdata; mem_pc_plus4 = pc;
        stall_wb = st; flush_wb = fl; fault_clr = clr;
        nm = m;
        if (fl) begin
            nm.valid = 0; nm.known = 0;
        end else if (!st) begin
            nm = '{valid: v, rw: rw, known: 1, rd: rd, src: src, f3: f3, alu: alu, rdata: rdata, pc: pc};
        end
        if (m.valid && !st && !fl) m_cnt = m_cnt + 1;
        f = is_fault(m);
        if (f && !st) begin
            if (!m_flag || clr) m_addr = m.alu;
            m_flag = 1;
        end else if (clr) begin
            m_flag = 0; m_addr = 0;
        end
        @(posedge clk);
        m = nm;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int c0;

    initial begin
        rst = 1'b1;
        drive_init: begin
            mem_valid = 0; mem_reg_write = 0; mem_rd = 0; mem_result_src = 0; mem_funct3 = 0;
            mem_alu_result = 0; mem_read_data = 0; mem_pc_plus4 = 0;
            stall_wb = 0; flush_wb = 0; fault_clr = 0;
        end
        model_reset();
        #1;
        check("rst_we", 32'(rf_we3), 0);
        check("rst_wd", rf_wd3, 0);
        check("rst_a3", 32'(rf_a3), 0);
        check("rst_cnt", 32'(retire_count), 0);
        check("rst_fault", 32'(load_fault), 0);
        check("rst_addr", fault_addr, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        check_outputs();

        // ALU write and retire
        drive(1, 1, 5, 0, 0, 32'h1234, 0, 0, 0, 0, 0);
        check("alu_a3", 32'(rf_a3), 5);
        check("alu_wd", rf_wd3, 32'h1234);
        check("alu_we", 32'(rf_we3), 1);
        idle();
        check("alu_retire", 32'(retire_count), 1);

        // Load extraction
        drive(1, 1, 3, 1, 3'd0, 32'h2, 32'h80FF7F01, 0, 0, 0, 0);
        check("lb", rf_wd3, 32'hFFFFFFFF);
        drive(1, 1, 3, 1, 3'd4, 32'h2, 32'h80FF7F01, 0, 0, 0, 0);
        check("lbu", rf_wd3, 32'h000000FF);
        drive(1, 1, 3, 1, 3'd1, 32'h2, 32'h80FF7F01, 0, 0, 0, 0);
        check("lh", rf_wd3, 32'hFFFF80FF);
        drive(1, 1, 3, 1, 3'd5, 32'h0, 32'h80FF7F01, 0, 0, 0, 0);
        check("lhu", rf_wd3, 32'h00007F01);
        drive(1, 1, 3, 1, 3'd2, 32'h0, 32'h80FF7F01, 0, 0, 0, 0);
        check("lw", rf_wd3, 32'h80FF7F01);

        // Misaligned loads and sticky fault
        drive(1, 1, 6, 1, 3'd2, 32'h1003, 32'h11223344, 0, 0, 0, 0);
        check("mis_lw_we", 32'(rf_we3), 0);
        drive(1, 1, 6, 1, 3'd1, 32'h2001, 32'h11223344, 0, 0, 0, 0);
        check("fault_set", 32'(load_fault), 1);
        check("fault_addr_first", fault_addr, 32'h1003);
        idle();
        check("fault_addr_kept", fault_addr, 32'h1003);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("fault_clr", 32'(load_fault), 0);

        // Stall then flush
        drive(1, 1, 7, 0, 0, 32'hCAFE, 0, 0, 0, 0, 0);
        c0 = m_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 9, 0, 0, $urandom, 0, 0, 1, 0, 0);
            check("stall_a3", 32'(rf_a3), 7);
            check("stall_we", 32'(rf_we3), 1);
            check("stall_cnt", 32'(retire_count), 32'(c0 % 16));
        end
        drive(1, 1, 9, 0, 0, 32'h55, 0, 0, 1, 1, 0);
        check("flush_we", 32'(rf_we3), 0);
        check("flush_cnt", 32'(retire_count), 32'(c0 % 16));

        // x0 guard and PC+4 source
        drive(1, 1, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        check("x0_we", 32'(rf_we3), 0);
        check("x0_fwd", 32'(fwd_valid), 0);
        c0 = m_cnt;
        drive(1, 1, 9, 2, 0, 32'h77, 0, 32'h40, 0, 0, 0);
        check("x0_retire", 32'(retire_count), 32'((c0 + 1) % 16));
        check("pc4_wd", rf_wd3, 32'h40);

        // Counter wrap
        idle();
        c0 = m_cnt;
        for (int i = 0; i < 16; i++) drive(1, 1, 2, 0, 0, 32'(i), 0, 0, 0, 0, 0);
        idle();
        check("wrap", 32'(retire_count), 32'(c0 % 16));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit [2:0] f3;
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1 && f3 <= 3'd1) f3 = f3 + 3'd4;
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, 5'($urandom),
                  2'($urandom), f3, $urandom, $urandom, $urandom,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0);
        end

        // Async reset between edges with a live write in WB
        drive(1, 1, 4, 0, 0, 32'hABCD, 0, 0, 0, 0, 0);
        check("pre_rst_we", 32'(rf_we3), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_we", 32'(rf_we3), 0);
        check("async_rst_cnt", 32'(retire_count), 0);
        check("async_rst_fault", 32'(load_fault), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_outputs();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline stage of the RISC-V core; sits directly upstream of the register file write port.
- Registers the MEM-stage result and extracts and sign- or zero-extends load data.
- Selects the writeback value and drives the register file's destination address, write data and write enable.
- Also provides forwarding outputs, a retired-instruction counter and sticky load-fault reporting.

Parameters:
CNT_W, 32, width of retire counter (wraps at 2^CNT_W).
X0_GUARD, 1, when 1 suppress every write with rd==0 (the register file does not protect x0).

Ports:
clk  in  1  rising-edge clock, shared with the register file.
rst  in  1  asynchronous, active-high reset.
mem_valid  in  1  MEM stage holds a valid instruction.
mem_reg_write  in  1  instruction writes rd.
mem_rd  in  5  destination register.
mem_result_src  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
mem_funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
mem_alu_result  in  32  ALU result; for loads, the byte address.
mem_read_data  in  32  aligned data-memory word.
mem_pc_plus4  in  32  PC+4 of the instruction.
stall_wb  in  1  hold WB register contents.
flush_wb  in  1  kill the instruction entering WB.
fault_clr  in  1  clear sticky fault.
rf_a3  out  5  register-file destination address.
rf_wd3  out  32  register-file write data.
rf_we3  out  1  register-file write enable.
fwd_valid  out  1  equals rf_we3; for the hazard unit.
fwd_rd  out  5  equals rf_a3.
fwd_data  out  32  equals rf_wd3.
retire_count  out  CNT_W  instructions retired.
load_fault  out  1  sticky misaligned/illegal-load flag.
fault_addr  out  32  address of first faulting load since last clear.

Behaviour:
- Reset (async, rst=1): WB register cleared (wb_valid=0, all fields 0).
  - Outputs on reset: rf_we3=0, rf_a3=0, rf_wd3=0, fwd_* = 0, retire_count=0, load_fault=0, fault_addr=0.
- WB register update at posedge clk, by priority:
  - flush_wb=1: wb_valid<=0, other fields don't care. Flush overrides stall.
  - else stall_wb=1: all WB fields hold.
  - else: capture all mem_* fields; wb_valid<=mem_valid.
- Latency: one cycle from mem_* inputs to rf_* outputs. rf_* are combinational from the WB register.
- Load extraction, with off = wb_alu_result[1:0]:
  - LB/LBU: byte at bits [8*off+7 : 8*off], sign-extended or zero-extended.
  - LH/LHU: halfword at [16*off[1]+15 : 16*off[1]].
  - LW: full word.
- Fault condition (result_src==01 only), evaluated when wb_valid=1:
  - LH/LHU with off[0]=1;
  - LW with off!=0;
  - funct3 in {011,110,111}.
- Writeback mux: 00/11 -> wb_alu_result, 01 -> extracted load, 10 -> wb_pc_plus4.
- rf_we3 = wb_valid & wb_reg_write & ~fault & ~(X0_GUARD & rd==0).
  - rf_a3 = wb_rd and rf_wd3 = mux output, even when rf_we3=0.
  - During a stall the same write is re-presented each cycle; this is idempotent.
- retire_count increments by 1 at an edge where wb_valid=1 and stall_wb=0 and flush_wb=0. Faulting instructions still count. Wraps modulo 2^CNT_W.
- Sticky fault flag:
  - load_fault sets at the edge where a fault is present in WB and stall_wb=0.
  - fault_addr is captured only if load_fault was 0 (first fault wins).
  - fault_clr clears both; a simultaneous new fault wins, setting the flag and capturing the new address.
- Reset mid-stall or mid-fault discards the WB instruction; no write occurs.

Test Plan:
- ALU write: mem_valid=1, reg_write=1, rd=5, src=00, alu=0x1234 -> next cycle rf_a3=5, rf_wd3=0x1234, rf_we3=1; after the following edge retire_count=1.
- Load extraction:
  - read_data=0x80FF7F01, alu=0x2, LB -> rf_wd3=0xFFFFFFFF.
  - Same with LBU -> 0x000000FF.
  - LH at alu=0x2 -> 0xFFFF80FF.
  - LHU at alu=0x0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Misaligned LW at alu=0x1003 -> rf_we3=0; load_fault=1, fault_addr=0x1003.
  - Second misaligned LH at 0x2001 keeps fault_addr=0x1003.
  - fault_clr pulse -> flag 0.
- Stall then flush:
  - stall_wb=1 for 3 cycles holds rd=7 write and retire_count is unchanged.
  - flush_wb together with stall -> rf_we3=0 next cycle and no retire increment.
- x0 guard: rd=0, reg_write=1, alu=0xDEADBEEF -> rf_we3=0, fwd_valid=0; retire_count still increments.
  - src=10 with pc_plus4=0x40 -> rf_wd3=0x40.
- Async reset asserted mid-cycle between edges with a valid write in WB -> rf_we3 drops to 0 immediately; retire_count=0.
  - With CNT_W=4, 16 retires wrap the count to 0.
